// File: rtl/seq_match_controller_if.sv
// ----------------------------------------------------------------------------
// seq_match_controller_if
// Purpose: serial bit-stream handshake between a bit source and the
//          pattern-match controller. A bit transfers on a clock edge where
//          bit_valid && bit_ready.
// Signals:
//   bit_valid  source -> controller  source presents a bit
//   bit_in     source -> controller  the data bit
//   bit_ready  controller -> source  controller will consume the bit this cycle
// Modports: master = bit source, slave = controller.
// ----------------------------------------------------------------------------
interface seq_match_controller_if;
    logic bit_valid;
    logic bit_in;
    logic bit_ready;

    modport master (
        output bit_valid,
        output bit_in,
        input  bit_ready
    );

    modport slave (
        input  bit_valid,
        input  bit_in,
        output bit_ready
    );
endinterface

// File: rtl/seq_match_controller.sv
// ----------------------------------------------------------------------------
// seq_match_controller
// Purpose: programmable serial pattern matcher. Holds a runtime-loaded pattern
//          of 1..MAX_LEN bits, consumes bits over a valid/ready handshake,
//          detects overlapping or non-overlapping matches, counts them
//          (saturating) and stops the stream once a nonzero threshold is hit.
// Optional feature: define SEQ_MATCH_TIMEOUT_EN to enable the idle-gap
//          timeout (TIMEOUT_CYC cycles without an accepted bit in RUN returns
//          to IDLE and sets the sticky timeout flag). Undefined: timeout = 0.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_we                load cfg_* registers (IDLE only)
//   cfg_pattern/len       pattern (bit [len-1] arrives first) and its length
//   cfg_overlap           1 = overlapping matches
//   cfg_threshold         match count that ends the run, 0 = free-run
//   start, stop           arm from IDLE/DONE; abort to IDLE (stop wins)
//   bit_if (slave)        bit_valid / bit_in / bit_ready handshake
//   match_pulse           1-cycle pulse per match (cycle after completing bit)
//   match_count           saturating match count since last start
//   busy, done            state == RUN, state == DONE
//   cfg_err               1-cycle pulse: start with an illegal stored length
//   timeout               sticky idle-gap timeout flag (optional feature)
// ----------------------------------------------------------------------------
module seq_match_controller #(
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [MAX_LEN-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_overlap,
    input  logic [CNT_W-1:0]     cfg_threshold,
    input  logic                 start,
    input  logic                 stop,
    seq_match_controller_if.slave bit_if,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_count,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;

    logic [MAX_LEN-2:0]   hist_q;      // top history bit is never compared, so not stored
    logic [LEN_W-1:0]     fill_q;
    logic [MAX_LEN-1:0]   pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovl_q;
    logic [CNT_W-1:0]     thr_q;

    logic                 ready_c;
    logic                 accept_c;
    logic [MAX_LEN-1:0]   hist_new_c;
    logic [MAX_LEN-1:0]   mask_c;
    logic [LEN_W:0]       fill_inc_c;
    logic [LEN_W-1:0]     fill_next_c;
    logic                 is_match_c;
    logic [CNT_W-1:0]     cnt_inc_c;
    logic                 thr_hit_c;
    logic                 len_ok_c;
    logic                 tmo_hit_c;
    logic                 enter_run_c;

    logic                 match_pulse_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 cfg_err_d;

    // Handshake: ready only while running and not being aborted.
    assign ready_c          = (state_q == S_RUN) && !stop;
    assign bit_if.bit_ready = ready_c;
    assign accept_c         = bit_if.bit_valid && ready_c;

    // Match datapath.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i < int'(len_q)) mask_c[i] = 1'b1;
        end
        hist_new_c  = {hist_q, bit_if.bit_in};
        fill_inc_c  = (LEN_W+1)'(fill_q) + (LEN_W+1)'(1);
        is_match_c  = accept_c
                   && (fill_inc_c >= (LEN_W+1)'(len_q))
                   && (((hist_new_c ^ pat_q) & mask_c) == '0);
        // Non-overlap restarts the fill so the completing bit is not reused.
        if (is_match_c && !ovl_q)
            fill_next_c = '0;
        else if (fill_inc_c > (LEN_W+1)'(MAX_LEN))
            fill_next_c = LEN_W'(MAX_LEN);
        else
            fill_next_c = LEN_W'(fill_inc_c);
        cnt_inc_c   = (&match_count) ? match_count : match_count + CNT_W'(1);
        thr_hit_c   = is_match_c && (thr_q != '0) && (cnt_inc_c == thr_q);
        len_ok_c    = (len_q != '0) && ((LEN_W+1)'(len_q) <= (LEN_W+1)'(MAX_LEN));
    end

`ifdef SEQ_MATCH_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

    logic [GAP_W-1:0] gap_q;

    // Leaving on the cycle whose increment would bring the gap to TIMEOUT_CYC.
    assign tmo_hit_c = (state_q == S_RUN) && !accept_c
                    && (gap_q == GAP_W'(TIMEOUT_CYC - 1));

    // Idle-gap counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_q   <= '0;
            timeout <= 1'b0;
        end else if (enter_run_c) begin
            gap_q   <= '0;
            timeout <= 1'b0;
        end else if (state_q == S_RUN) begin
            gap_q <= accept_c ? '0 : gap_q + GAP_W'(1);
            if (tmo_hit_c && !stop) timeout <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign tmo_hit_c          = 1'b0;
    assign timeout            = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; stop has priority over start and threshold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !stop && len_ok_c) state_d = S_RUN;
            S_RUN: begin
                if (stop)           state_d = S_IDLE;
                else if (thr_hit_c) state_d = S_DONE;
                else if (tmo_hit_c) state_d = S_IDLE;
            end
            S_DONE: begin
                if (stop)       state_d = S_IDLE;
                else if (start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs (next values of the registered status outputs).
    always_comb begin
        match_pulse_d = is_match_c;
        busy_d        = (state_d == S_RUN);
        done_d        = (state_d == S_DONE);
        cfg_err_d     = (state_q == S_IDLE) && start && !stop && !len_ok_c;
        enter_run_c   = (state_d == S_RUN) && (state_q != S_RUN);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_pulse <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            match_pulse <= match_pulse_d;
            busy        <= busy_d;
            done        <= done_d;
            cfg_err     <= cfg_err_d;
        end
    end

    // Config, history, fill and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            thr_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            match_count <= '0;
        end else begin
            if ((state_q == S_IDLE) && cfg_we) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                thr_q <= cfg_threshold;
            end
            if (enter_run_c) begin
                hist_q      <= '0;
                fill_q      <= '0;
                match_count <= '0;
            end else if (accept_c) begin
                hist_q <= hist_new_c[MAX_LEN-2:0];
                fill_q <= fill_next_c;
                if (is_match_c) match_count <= cnt_inc_c;
            end
        end
    end

endmodule

// File: tb/tb_seq_match_controller.sv
module tb_seq_match_controller;

    logic       clk;
    logic       reset_n;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_threshold;
    logic       start;
    logic       stop;
    logic       match_pulse;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic       timeout;

    int checks;
    int failures;

    seq_match_controller_if bif ();

    seq_match_controller #(
        .MAX_LEN     (8),
        .LEN_W       (4),
        .CNT_W       (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .cfg_threshold (cfg_threshold),
        .start         (start),
        .stop          (stop),
        .bit_if        (bif),
        .match_pulse   (match_pulse),
        .match_count   (match_count),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic [7:0] thr);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len;
        cfg_overlap = ovl; cfg_threshold = thr;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    // Drive n bits back-to-back, first bit = bits[n-1]; record match_pulse per bit.
    task automatic send_bits(input logic [15:0] bits, input int n, output logic [15:0] pulses);
        pulses = '0;
        for (int k = 0; k < n; k++) begin
            bif.bit_valid = 1'b1;
            bif.bit_in    = bits[n-1-k];
            step();
            pulses[n-1-k] = match_pulse;
        end
        bif.bit_valid = 1'b0;
        bif.bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        checks++;
        if ({match_pulse, match_count, busy, done, cfg_err, timeout, bif.bit_ready} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {match_pulse, match_count, busy, done, cfg_err, timeout, bif.bit_ready});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_overlap_010();
        logic [15:0] p;
        do_cfg(8'b010, 4'd3, 1'b1, 8'd0);
        do_start();
        checks++;
        if (busy !== 1'b1 || bif.bit_ready !== 1'b1) begin
            failures++; $display("FAIL t1_armed got busy=%b ready=%b exp=1,1", busy, bif.bit_ready);
        end
        send_bits(16'b0101010, 7, p);
        checks++;
        if (p[6:0] !== 7'b0010101) begin
            failures++; $display("FAIL t1_pulses got=%b exp=0010101", p[6:0]);
        end
        step();
        checks++;
        if (match_count !== 8'd3 || match_pulse !== 1'b0) begin
            failures++; $display("FAIL t1_count got cnt=%0d pulse=%b exp=3,0", match_count, match_pulse);
        end
        do_stop();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL t1_stop got busy=%b done=%b exp=0,0", busy, done);
        end
    endtask

    task automatic test_pattern_1001();
        logic [15:0] p;
        do_cfg(8'b1001, 4'd4, 1'b1, 8'd0);
        do_start();
        send_bits(16'b1001001, 7, p);
        checks++;
        if (p[6:0] !== 7'b0001001 || match_count !== 8'd2) begin
            failures++; $display("FAIL t2_ovl got pulses=%b cnt=%0d exp=0001001,2", p[6:0], match_count);
        end
        do_stop();
        do_cfg(8'b1001, 4'd4, 1'b0, 8'd0);
        do_start();
        send_bits(16'b1001001, 7, p);
        checks++;
        if (p[6:0] !== 7'b0001000 || match_count !== 8'd1) begin
            failures++; $display("FAIL t2_nonovl got pulses=%b cnt=%0d exp=0001000,1", p[6:0], match_count);
        end
        // Stop cycle: ready low, bit not consumed.
        bif.bit_valid = 1'b1; bif.bit_in = 1'b1; stop = 1'b1;
        #1;
        checks++;
        if (bif.bit_ready !== 1'b0) begin
            failures++; $display("FAIL t2_stop_ready got=%b exp=0", bif.bit_ready);
        end
        step();
        stop = 1'b0; bif.bit_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || match_count !== 8'd1) begin
            failures++; $display("FAIL t2_stop_state got busy=%b cnt=%0d exp=0,1", busy, match_count);
        end
    endtask

    task automatic test_threshold();
        logic [15:0] p;
        do_cfg(8'b010, 4'd3, 1'b1, 8'd2);
        do_start();
        send_bits(16'b01010, 5, p);
        checks++;
        if (p[4:0] !== 5'b00101 || match_count !== 8'd2) begin
            failures++; $display("FAIL t3_pulses got pulses=%b cnt=%0d exp=00101,2", p[4:0], match_count);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bif.bit_ready !== 1'b0) begin
            failures++; $display("FAIL t3_done got done=%b busy=%b ready=%b exp=1,0,0",
                                 done, busy, bif.bit_ready);
        end
        // Bits 6 and 7 would complete a third match if they were consumed.
        send_bits(16'b10, 2, p);
        checks++;
        if (p[1:0] !== 2'b00 || match_count !== 8'd2 || done !== 1'b1) begin
            failures++; $display("FAIL t3_no_consume got pulses=%b cnt=%0d done=%b exp=00,2,1",
                                 p[1:0], match_count, done);
        end
        do_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || match_count !== 8'd0) begin
            failures++; $display("FAIL t3_rearm got busy=%b done=%b cnt=%0d exp=1,0,0",
                                 busy, done, match_count);
        end
        do_stop();
    endtask

    task automatic test_cfg_err();
        do_cfg(8'b1, 4'd0, 1'b0, 8'd0);
        do_start();
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL t4_len0 got err=%b busy=%b exp=1,0", cfg_err, busy);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++; $display("FAIL t4_err_pulse got=%b exp=0", cfg_err);
        end
        do_cfg(8'b1, 4'd9, 1'b0, 8'd0);
        do_start();
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL t4_len9 got err=%b busy=%b exp=1,0", cfg_err, busy);
        end
        step();
    endtask

    task automatic test_saturation();
        do_cfg(8'b1, 4'd1, 1'b1, 8'd0);
        do_start();
        bif.bit_valid = 1'b1; bif.bit_in = 1'b1;
        for (int k = 0; k < 260; k++) step();
        checks++;
        if (match_count !== 8'hFF || match_pulse !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL t_sat got cnt=%0d pulse=%b busy=%b exp=255,1,1",
                                 match_count, match_pulse, busy);
        end
        bif.bit_valid = 1'b0;
        do_stop();
    endtask

    task automatic test_back_to_back_reset();
        logic [15:0] p;
        do_cfg(8'b010, 4'd3, 1'b1, 8'd0);
        do_start();
        send_bits(16'b010, 3, p);
        checks++;
        if (match_count !== 8'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL t5_pre got cnt=%0d busy=%b exp=1,1", match_count, busy);
        end
        bif.bit_valid = 1'b1; bif.bit_in = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({match_pulse, match_count, busy, done, cfg_err, timeout, bif.bit_ready} !== 14'h0) begin
            failures++; $display("FAIL t5_async got=%h exp=0",
                                 {match_pulse, match_count, busy, done, cfg_err, timeout, bif.bit_ready});
        end
        #1 reset_n = 1'b1;
        send_bits(16'b1010, 4, p);
        checks++;
        if (p[3:0] !== 4'b0000 || busy !== 1'b0 || match_count !== 8'd0) begin
            failures++; $display("FAIL t5_after got pulses=%b busy=%b cnt=%0d exp=0000,0,0",
                                 p[3:0], busy, match_count);
        end
        // Config registers were cleared by reset, so stored length is 0.
        do_start();
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL t5_cfg_cleared got err=%b busy=%b exp=1,0", cfg_err, busy);
        end
        step();
    endtask

    task automatic test_timeout();
        do_cfg(8'b010, 4'd3, 1'b1, 8'd0);
        do_start();
`ifdef SEQ_MATCH_TIMEOUT_EN
        step(); step(); step();
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            failures++; $display("FAIL t6_before got busy=%b tmo=%b exp=1,0", busy, timeout);
        end
        step();
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b1) begin
            failures++; $display("FAIL t6_fire got busy=%b tmo=%b exp=0,1", busy, timeout);
        end
        step(); step();
        checks++;
        if (timeout !== 1'b1) begin
            failures++; $display("FAIL t6_sticky got=%b exp=1", timeout);
        end
        do_start();
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            failures++; $display("FAIL t6_clear got busy=%b tmo=%b exp=1,0", busy, timeout);
        end
`else
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            failures++; $display("FAIL t6_disabled got busy=%b tmo=%b exp=1,0", busy, timeout);
        end
`endif
        do_stop();
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_threshold = '0; start = 1'b0; stop = 1'b0;
        bif.bit_valid = 1'b0; bif.bit_in = 1'b0;
        test_reset();
        test_overlap_010();
        test_pattern_1001();
        test_threshold();
        test_cfg_err();
        test_saturation();
        test_timeout();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
